// File: rtl/i2c_slave.sv
// ============================================================================
//  Module   : i2c_slave
//  Brief    : 7-bit address I2C target; receives write bytes, sends read bytes.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_RX       = 3'd3,
        S_RX_ACK   = 3'd4,
        S_TX       = 3'd5,
        S_TX_ACK   = 3'd6
    } state_t;

    // Synchronizer chains reset high so no false START appears out of reset
    logic r_scl_m, r_scl_s, r_scl_d;
    logic r_sda_m, r_sda_s, r_sda_d;

    state_t     r_state,   w_state;
    logic [2:0] r_bit_cnt, w_bit_cnt;
    logic       r_ack_ph,  w_ack_ph;
    logic [7:0] r_shreg,   w_shreg;
    logic [7:0] r_txsh,    w_txsh;
    logic       r_rw,      w_rw;
    logic       r_sda_oe,  w_sda_oe;
    logic [7:0] r_rx_data, w_rx_data;
    logic       r_rx_valid, w_rx_valid;
    logic       r_tx_req,  w_tx_req;
    logic       r_busy,    w_busy;

    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [2:0] w_tx_idx;

    assign w_scl_rise = r_scl_s & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s & r_scl_d;
    assign w_start    = r_scl_s & r_scl_d & r_sda_d & ~r_sda_s;
    assign w_stop     = r_scl_s & r_scl_d & ~r_sda_d & r_sda_s;
    assign w_tx_idx   = 3'd6 - r_bit_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scl_m    <= 1'b1;
            r_scl_s    <= 1'b1;
            r_scl_d    <= 1'b1;
            r_sda_m    <= 1'b1;
            r_sda_s    <= 1'b1;
            r_sda_d    <= 1'b1;
            r_state    <= S_IDLE;
            r_bit_cnt  <= 3'd0;
            r_ack_ph   <= 1'b0;
            r_shreg    <= 8'h00;
            r_txsh     <= 8'h00;
            r_rw       <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_scl_m    <= scl_in;
            r_scl_s    <= r_scl_m;
            r_scl_d    <= r_scl_s;
            r_sda_m    <= sda_in;
            r_sda_s    <= r_sda_m;
            r_sda_d    <= r_sda_s;
            r_state    <= w_state;
            r_bit_cnt  <= w_bit_cnt;
            r_ack_ph   <= w_ack_ph;
            r_shreg    <= w_shreg;
            r_txsh     <= w_txsh;
            r_rw       <= w_rw;
            r_sda_oe   <= w_sda_oe;
            r_rx_data  <= w_rx_data;
            r_rx_valid <= w_rx_valid;
            r_tx_req   <= w_tx_req;
            r_busy     <= w_busy;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_bit_cnt  = r_bit_cnt;
        w_ack_ph   = r_ack_ph;
        w_shreg    = r_shreg;
        w_txsh     = r_txsh;
        w_rw       = r_rw;
        w_sda_oe   = r_sda_oe;
        w_rx_data  = r_rx_data;
        w_rx_valid = 1'b0;
        w_tx_req   = 1'b0;
        w_busy     = r_busy;

        if (w_start) begin
            w_state   = S_ADDR;
            w_bit_cnt = 3'd0;
            w_sda_oe  = 1'b0;
            w_busy    = 1'b0;
        end else if (w_stop) begin
            w_state  = S_IDLE;
            w_sda_oe = 1'b0;
            w_busy   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_sda_oe = 1'b0;
                end
                S_ADDR: begin
                    if (w_scl_rise) begin
                        w_shreg   = {r_shreg[6:0], r_sda_s};
                        w_bit_cnt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            if (r_shreg[6:0] == SLAVE_ADDR) begin
                                w_rw     = r_sda_s;
                                w_busy   = 1'b1;
                                w_ack_ph = 1'b0;
                                w_state  = S_ADDR_ACK;
                            end else begin
                                w_state = S_IDLE;
                            end
                        end
                    end
                end
                S_ADDR_ACK, S_RX_ACK: begin
                    // First fall starts the ACK low phase, second fall ends it
                    if (w_scl_fall) begin
                        if (!r_ack_ph) begin
                            w_sda_oe = 1'b1;
                            w_ack_ph = 1'b1;
                        end else begin
                            w_sda_oe  = 1'b0;
                            w_bit_cnt = 3'd0;
                            if (r_state == S_ADDR_ACK && r_rw) begin
                                w_txsh   = tx_data;
                                w_tx_req = 1'b1;
                                w_sda_oe = ~tx_data[7];
                                w_state  = S_TX;
                            end else begin
                                w_state = S_RX;
                            end
                        end
                    end
                end
                S_RX: begin
                    if (w_scl_rise) begin
                        w_shreg   = {r_shreg[6:0], r_sda_s};
                        w_bit_cnt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_rx_data  = {r_shreg[6:0], r_sda_s};
                            w_rx_valid = 1'b1;
                            w_ack_ph   = 1'b0;
                            w_state    = S_RX_ACK;
                        end
                    end
                end
                S_TX: begin
                    // bit_cnt counts bits already handed to the bus after the MSB
                    if (w_scl_fall) begin
                        if (r_bit_cnt == 3'd7) begin
                            w_sda_oe = 1'b0;
                            w_ack_ph = 1'b0;
                            w_state  = S_TX_ACK;
                        end else begin
                            w_sda_oe  = ~r_txsh[w_tx_idx];
                            w_bit_cnt = r_bit_cnt + 3'd1;
                        end
                    end
                end
                S_TX_ACK: begin
                    if (w_scl_rise) begin
                        if (r_sda_s) begin
                            w_state = S_IDLE;
                            w_busy  = 1'b0;
                        end else begin
                            w_ack_ph = 1'b1;
                        end
                    end else if (w_scl_fall && r_ack_ph) begin
                        w_txsh    = tx_data;
                        w_tx_req  = 1'b1;
                        w_sda_oe  = ~tx_data[7];
                        w_bit_cnt = 3'd0;
                        w_state   = S_TX;
                    end
                end
                default: begin
                    w_state  = S_IDLE;
                    w_sda_oe = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe   = r_sda_oe;
    assign tx_req   = r_tx_req;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave.sv
// ============================================================================
//  Module   : tb_i2c_slave
//  Brief    : Bus-level bench driving i2c_slave as an I2C master with a scoreboard.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_i2c_slave;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       sda_line;

    int checks = 0;
    int passes = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         tx_req_cnt = 0;
    int         oe_cnt = 0;
    int         pulse_err = 0;
    logic       prev_rxv = 1'b0;
    logic       prev_txr = 1'b0;

    assign sda_line = m_sda & ~sda_oe;

    i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (m_scl),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) obs_q.push_back(rx_data);
        if (tx_req) tx_req_cnt++;
        if (sda_oe) oe_cnt++;
        if ((rx_valid && prev_rxv) || (tx_req && prev_txr)) pulse_err++;
        prev_rxv = rx_valid;
        prev_txr = tx_req;
    end

    // ---------------- master bus primitives ----------------
    task automatic qwait();
        repeat (5) @(posedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; qwait();
        m_scl = 1'b1; qwait();
        m_sda = 1'b0; qwait();
        m_scl = 1'b0; qwait();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; qwait();
        m_scl = 1'b1; qwait();
        m_sda = 1'b1; qwait();
        qwait();
    endtask

    task automatic write_bit(input logic b);
        m_sda = b; qwait();
        m_scl = 1'b1; qwait(); qwait();
        m_scl = 1'b0; qwait();
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; qwait();
        m_scl = 1'b1; qwait();
        b = sda_line; qwait();
        m_scl = 1'b0; qwait();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic ack_bit, input logic [7:0] next_tx,
                             output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
            if (i == 7) tx_data = next_tx;
        end
        write_bit(ack_bit);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (4) @(posedge clk);
        #1;
        checks++; if (sda_oe !== 1'b0) $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); else passes++;
        checks++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h expected 00", rx_data); else passes++;
        checks++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); else passes++;
        checks++; if (tx_req !== 1'b0) $display("FAIL reset_tx_req: got %b expected 0", tx_req); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
        reset = 1'b1;
        qwait();
    endtask

    task automatic test_write();
        logic       ack;
        logic [7:0] bytes [3] = '{8'hA0, 8'h3C, 8'hC3};
        i2c_start();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) exp_q.push_back(bytes[i]);
            write_byte(bytes[i], ack);
            checks++; if (ack !== 1'b0) $display("FAIL write_ack%0d: got %b expected 0", i, ack); else passes++;
        end
        checks++; if (busy !== 1'b1) $display("FAIL write_busy: got %b expected 1", busy); else passes++;
        i2c_stop();
        checks++; if (busy !== 1'b0) $display("FAIL write_busy_stop: got %b expected 0", busy); else passes++;
        checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL write_rx_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        else passes++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== e) $display("FAIL write_rx_data: got %h expected %h", o, e); else passes++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_mismatch();
        logic ack;
        int   oe0;
        oe0 = oe_cnt;
        i2c_start();
        write_byte(8'hA2, ack);
        checks++; if (ack !== 1'b1) $display("FAIL mismatch_ack: got %b expected 1", ack); else passes++;
        write_byte(8'h55, ack);
        checks++; if (ack !== 1'b1) $display("FAIL mismatch_data_ack: got %b expected 1", ack); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL mismatch_busy: got %b expected 0", busy); else passes++;
        i2c_stop();
        checks++; if (oe_cnt !== oe0) $display("FAIL mismatch_sda_oe: got %0d cycles expected 0", oe_cnt - oe0); else passes++;
        checks++; if (obs_q.size() !== 0) $display("FAIL mismatch_rx_valid: got %0d expected 0", obs_q.size()); else passes++;
        obs_q.delete();
    endtask

    task automatic test_read();
        logic       ack;
        logic [7:0] d;
        int         tr0;
        tr0 = tx_req_cnt;
        tx_data = 8'h5A;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hA5);
        i2c_start();
        write_byte(8'hA1, ack);
        checks++; if (ack !== 1'b0) $display("FAIL read_addr_ack: got %b expected 0", ack); else passes++;
        read_byte(1'b0, 8'hA5, d);
        checks++; if (d !== exp_q[0]) $display("FAIL read_byte0: got %h expected %h", d, exp_q[0]); else passes++;
        void'(exp_q.pop_front());
        read_byte(1'b1, 8'h00, d);
        checks++; if (d !== exp_q[0]) $display("FAIL read_byte1: got %h expected %h", d, exp_q[0]); else passes++;
        void'(exp_q.pop_front());
        checks++; if (sda_oe !== 1'b0) $display("FAIL read_nack_sda_oe: got %b expected 0", sda_oe); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL read_nack_busy: got %b expected 0", busy); else passes++;
        checks++; if (tx_req_cnt - tr0 !== 2) $display("FAIL read_tx_req: got %0d expected 2", tx_req_cnt - tr0); else passes++;
        i2c_stop();
    endtask

    task automatic test_repeated_start();
        logic       ack;
        logic [7:0] d;
        int         tr0;
        tr0 = tx_req_cnt;
        tx_data = 8'h96;
        i2c_start();
        write_byte(8'hA0, ack);
        checks++; if (ack !== 1'b0) $display("FAIL rs_waddr_ack: got %b expected 0", ack); else passes++;
        exp_q.push_back(8'h10);
        write_byte(8'h10, ack);
        checks++; if (ack !== 1'b0) $display("FAIL rs_wdata_ack: got %b expected 0", ack); else passes++;
        i2c_start();
        write_byte(8'hA1, ack);
        checks++; if (ack !== 1'b0) $display("FAIL rs_raddr_ack: got %b expected 0", ack); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL rs_busy: got %b expected 1", busy); else passes++;
        read_byte(1'b1, 8'h00, d);
        checks++; if (d !== 8'h96) $display("FAIL rs_read_byte: got %h expected 96", d); else passes++;
        checks++; if (tx_req_cnt - tr0 !== 1) $display("FAIL rs_tx_req: got %0d expected 1", tx_req_cnt - tr0); else passes++;
        checks++;
        if (obs_q.size() !== 1 || exp_q.size() !== 1) $display("FAIL rs_rx_count: got %0d expected 1", obs_q.size());
        else if (obs_q[0] !== exp_q[0]) $display("FAIL rs_rx_data: got %h expected %h", obs_q[0], exp_q[0]);
        else passes++;
        obs_q.delete(); exp_q.delete();
        i2c_stop();
    endtask

    task automatic test_stop_mid_byte();
        logic ack;
        i2c_start();
        write_byte(8'hA0, ack);
        checks++; if (ack !== 1'b0) $display("FAIL stopmid_ack: got %b expected 0", ack); else passes++;
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
        i2c_stop();
        qwait();
        checks++; if (obs_q.size() !== 0) $display("FAIL stopmid_rx_valid: got %0d expected 0", obs_q.size()); else passes++;
        checks++; if (sda_oe !== 1'b0) $display("FAIL stopmid_sda_oe: got %b expected 0", sda_oe); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL stopmid_busy: got %b expected 0", busy); else passes++;
        obs_q.delete();
    endtask

    task automatic test_reset_mid_ack();
        logic       ack;
        logic [7:0] a = 8'hA0;
        int         rv0, tr0;
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(a[i]);
        #1;
        checks++; if (sda_oe !== 1'b1) $display("FAIL rstack_oe_before: got %b expected 1", sda_oe); else passes++;
        #2 reset = 1'b0;
        #1;
        checks++; if (sda_oe !== 1'b0) $display("FAIL rstack_oe_async: got %b expected 0", sda_oe); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rstack_busy: got %b expected 0", busy); else passes++;
        checks++; if (rx_data !== 8'h00) $display("FAIL rstack_rx_data: got %h expected 00", rx_data); else passes++;
        rv0 = obs_q.size(); tr0 = tx_req_cnt;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rx_valid !== 1'b0 || tx_req !== 1'b0)
            $display("FAIL rstack_pulses: got rx_valid=%b tx_req=%b expected 0 0", rx_valid, tx_req); else passes++;
        reset = 1'b1;
        m_sda = 1'b1; qwait();
        m_scl = 1'b1; qwait();
        m_scl = 1'b0; qwait();
        i2c_start();
        write_byte(8'hA0, ack);
        checks++; if (ack !== 1'b0) $display("FAIL rstack_reack: got %b expected 0", ack); else passes++;
        i2c_stop();
        checks++; if (obs_q.size() !== rv0 || tx_req_cnt !== tr0)
            $display("FAIL rstack_no_pulse: got rx=%0d tx=%0d expected 0 0", obs_q.size() - rv0, tx_req_cnt - tr0); else passes++;
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_write();
        test_mismatch();
        test_read();
        test_repeated_start();
        test_stop_mid_byte();
        test_reset_mid_ack();
        checks++; if (pulse_err !== 0) $display("FAIL pulse_width: got %0d long pulses expected 0", pulse_err); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
